// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one registered ALU (AND/OR/XOR/ADD) between four requesters.
// While idle it picks a requester round-robin, latches that requester's
// opcode and operands, runs the operation for ALU_LAT cycles, and then
// returns the result together with the winner's index.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   req      per-requester request (level)
//   op_bus   2-bit opcode per requester, op_bus[2i+1:2i] for requester i
//   a_bus    operand A per requester, WIDTH bits per slot
//   b_bus    operand B per requester, WIDTH bits per slot
//   gnt      one-hot grant, one-cycle pulse in the first EXEC cycle
//   busy     high while the sequencer is not IDLE
//   done     one-cycle result-valid pulse
//   done_id  index of the requester that owns result
//   result   ALU result, held until the next done
//   carry    carry-out of ADD, 0 for logic ops
//
// state | meaning
// IDLE  | sampling req, waiting for a requester
// EXEC  | operation in flight, execute counter running down
// DONE  | result valid, done asserted for this cycle
module alu_arbiter #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [7:0]         op_bus,
    input  logic [4*WIDTH-1:0] a_bus,
    input  logic [4*WIDTH-1:0] b_bus,
    output logic [3:0]         gnt,
    output logic               busy,
    output logic               done,
    output logic [1:0]         done_id,
    output logic [WIDTH-1:0]   result,
    output logic               carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         win_q, win_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         done_id_q, done_id_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;

    logic               pick_valid;
    logic [1:0]         pick_idx;
    logic [WIDTH:0]     alu_out;

    // Round-robin pick: search ptr+1, ptr+2, ptr+3, ptr. The loop walks
    // from lowest to highest priority so the last hit is the winner.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = ptr_q + 2'(k);
            end
        end
    end

    // Extra top bit carries the ADD carry-out; logic ops leave it 0.
    always_comb begin
        alu_out = '0;
        case (op_q)
            2'b00:   alu_out = {1'b0, a_q & b_q};
            2'b01:   alu_out = {1'b0, a_q | b_q};
            2'b10:   alu_out = {1'b0, a_q ^ b_q};
            default: alu_out = {1'b0, a_q} + {1'b0, b_q};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        gnt_d     = 4'b0000;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
        carry_d   = carry_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_idx;
                    op_d    = op_bus[2*pick_idx +: 2];
                    a_d     = a_bus[WIDTH*pick_idx +: WIDTH];
                    b_d     = b_bus[WIDTH*pick_idx +: WIDTH];
                    cnt_d   = 4'(ALU_LAT - 1);
                    gnt_d   = 4'b0001 << pick_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    result_d  = alu_out[WIDTH-1:0];
                    carry_d   = alu_out[WIDTH];
                    done_id_d = win_q;
                    ptr_d     = win_q;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= 2'd3;
            win_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign result  = result_q;
    assign carry   = carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: three instances with execute latencies 1, 3 and 4
// share the operand/opcode buses; each has its own reset and request lines.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic [7:0]  op_bus;
    logic [31:0] a_bus, b_bus;

    logic       rst1, rst3, rst4;
    logic [3:0] q1, q3, q4;
    logic [3:0] g1, g3, g4;
    logic       bz1, bz3, bz4, d1, d3, d4, c1, c3, c4;
    logic [1:0] id1, id3, id4;
    logic [7:0] r1, r3, r4;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(8), .ALU_LAT(1)) u1 (
        .clk(clk), .reset(rst1), .req(q1), .op_bus(op_bus), .a_bus(a_bus), .b_bus(b_bus),
        .gnt(g1), .busy(bz1), .done(d1), .done_id(id1), .result(r1), .carry(c1));
    alu_arbiter #(.WIDTH(8), .ALU_LAT(3)) u3 (
        .clk(clk), .reset(rst3), .req(q3), .op_bus(op_bus), .a_bus(a_bus), .b_bus(b_bus),
        .gnt(g3), .busy(bz3), .done(d3), .done_id(id3), .result(r3), .carry(c3));
    alu_arbiter #(.WIDTH(8), .ALU_LAT(4)) u4 (
        .clk(clk), .reset(rst4), .req(q4), .op_bus(op_bus), .a_bus(a_bus), .b_bus(b_bus),
        .gnt(g4), .busy(bz4), .done(d4), .done_id(id4), .result(r4), .carry(c4));

    typedef struct {
        logic [1:0] id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_r;
        logic       exp_c;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Background values in every slot, then the chosen requester's fields.
    task automatic load_slot(input logic [1:0] id, input logic [1:0] op,
                             input logic [7:0] a, input logic [7:0] b);
        op_bus = {4{~op}};
        a_bus  = 32'h9E6B3D17;
        b_bus  = 32'h2C85F4A1;
        op_bus[2*id +: 2] = op;
        a_bus[8*id +: 8]  = a;
        b_bus[8*id +: 8]  = b;
    endtask

    task automatic reset_u1();
        rst1 = 1'b1;
        q1   = 4'b0000;
        tick();
        tick();
        rst1 = 1'b0;
    endtask

    initial begin
        int prev;
        int lat;
        int done_cyc;
        int busy_cnt;
        logic [7:0] cap_r;
        logic [1:0] eid;

        vecs[0] = '{2'd0, 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[1] = '{2'd2, 2'b11, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{2'd2, 2'b10, 8'hFF, 8'h01, 8'hFE, 1'b0};
        vecs[3] = '{2'd1, 2'b01, 8'h0A, 8'h50, 8'h5A, 1'b0};
        vecs[4] = '{2'd3, 2'b11, 8'h80, 8'h80, 8'h00, 1'b1};
        vecs[5] = '{2'd0, 2'b11, 8'h12, 8'h34, 8'h46, 1'b0};
        vecs[6] = '{2'd3, 2'b00, 8'hAA, 8'h0F, 8'h0A, 1'b0};
        vecs[7] = '{2'd1, 2'b10, 8'h55, 8'hFF, 8'hAA, 1'b0};

        op_bus = '0; a_bus = '0; b_bus = '0;
        q1 = '0; q3 = '0; q4 = '0;
        rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
        tick();
        tick();
        rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;

        check("rst_gnt",    32'(g1),  32'h0);
        check("rst_busy",   32'(bz1), 32'h0);
        check("rst_done",   32'(d1),  32'h0);
        check("rst_doneid", 32'(id1), 32'h0);
        check("rst_result", 32'(r1),  32'h0);
        check("rst_carry",  32'(c1),  32'h0);

        // Single-requester vectors, latency 1.
        for (int i = 0; i < 8; i++) begin
            load_slot(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            q1 = 4'b0001 << vecs[i].id;
            tick();
            q1 = 4'b0000;
            check("vec_gnt",  32'(g1),  32'(4'b0001 << vecs[i].id));
            check("vec_busy", 32'(bz1), 32'h1);
            tick();
            check("vec_done",   32'(d1),  32'h1);
            check("vec_gnt_off",32'(g1),  32'h0);
            check("vec_result", 32'(r1),  32'(vecs[i].exp_r));
            check("vec_carry",  32'(c1),  32'(vecs[i].exp_c));
            check("vec_doneid", 32'(id1), 32'(vecs[i].id));
            tick();
            check("vec_done_off", 32'(d1),  32'h0);
            check("vec_idle",     32'(bz1), 32'h0);
            check("vec_hold",     32'(r1),  32'(vecs[i].exp_r));
        end

        // Fairness: all four requesting continuously from reset.
        reset_u1();
        load_slot(2'd0, 2'b00, 8'hFF, 8'hFF);
        q1 = 4'b1111;
        prev = -1;
        for (int s = 0; s < 6; s++) begin
            eid = 2'(s % 4);
            for (int k = 0; k < 8 && g1 == 4'b0000; k++) tick();
            check("fair_gnt", 32'(g1), 32'(4'b0001 << eid));
            for (int k = 0; k < 8 && !d1; k++) tick();
            check("fair_done",   32'(d1),  32'h1);
            check("fair_doneid", 32'(id1), 32'(eid));
            if (prev >= 0) check("fair_spacing", 32'(cyc - prev), 32'd3);
            prev = cyc;
            tick();
        end
        q1 = 4'b0000;

        // Alternation between requesters 1 and 3; operand change in EXEC.
        reset_u1();
        load_slot(2'd1, 2'b01, 8'h0F, 8'hF0);
        op_bus[7:6] = 2'b11;
        a_bus[31:24] = 8'h01;
        b_bus[31:24] = 8'h02;
        q1 = 4'b1010;
        for (int s = 0; s < 4; s++) begin
            eid = (s % 2 == 0) ? 2'd1 : 2'd3;
            for (int k = 0; k < 8 && g1 == 4'b0000; k++) tick();
            check("alt_gnt", 32'(g1), 32'(4'b0001 << eid));
            a_bus[15:8] = 8'h00;
            for (int k = 0; k < 8 && !d1; k++) tick();
            check("alt_done",   32'(d1),  32'h1);
            check("alt_doneid", 32'(id1), 32'(eid));
            check("alt_result", 32'(r1),  (eid == 2'd1) ? 32'hFF : 32'h03);
            a_bus[15:8] = 8'h0F;
            tick();
        end
        q1 = 4'b0000;

        // Reset during EXEC, latency 3.
        load_slot(2'd0, 2'b11, 8'hFF, 8'h01);
        q3 = 4'b0001;
        tick();
        q3 = 4'b0000;
        check("rmid_gnt", 32'(g3), 32'h1);
        tick();
        check("rmid_busy", 32'(bz3), 32'h1);
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        check("rmid_gnt0",  32'(g3),  32'h0);
        check("rmid_busy0", 32'(bz3), 32'h0);
        check("rmid_done0", 32'(d3),  32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rmid_no_done", 32'(d3), 32'h0);
        end
        check("rmid_result", 32'(r3), 32'h0);
        load_slot(2'd3, 2'b10, 8'h3C, 8'h0F);
        q3 = 4'b1000;
        tick();
        q3 = 4'b0000;
        check("rmid_gnt3", 32'(g3), 32'h8);
        lat = 1;
        while (!d3 && lat < 12) begin
            tick();
            lat++;
        end
        check("rmid_latency", 32'(lat), 32'd4);
        check("rmid_doneid",  32'(id3), 32'd3);
        check("rmid_res3",    32'(r3),  32'h33);

        // Latency 4.
        load_slot(2'd0, 2'b01, 8'h0A, 8'h50);
        q4 = 4'b0001;
        tick();
        q4 = 4'b0000;
        done_cyc = 0;
        busy_cnt = 0;
        cap_r    = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            if (d4 && done_cyc == 0) begin
                done_cyc = c;
                cap_r    = r4;
            end
            if (bz4) busy_cnt++;
            tick();
        end
        check("lat4_done_cycle", 32'(done_cyc), 32'd5);
        check("lat4_busy_cnt",   32'(busy_cnt), 32'd5);
        check("lat4_result",     32'(cap_r),    32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
